// File: rtl/frame_sched_pkg.sv
// Shared types and display constants for the vertical-blank frame scheduler.
package frame_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // 640x480 @ 60 Hz timing geometry
  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned H_TOTAL  = 800;
  localparam int unsigned V_LAST   = 525;

  // Sequence starts at the first blank line; abort a few lines before active video
  localparam int unsigned DEF_BLANK_LINE    = V_ACTIVE;
  localparam int unsigned DEF_DEADLINE_LINE = 522;

  // Saturating 8-bit increment for the overrun counter
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/frame_scheduler_line_event.sv
// Combinational strobe marking the start (h_count==0) of one vertical line.
module line_event
  import frame_sched_pkg::*;
#(
  parameter int unsigned LINE = DEF_BLANK_LINE
) (
  input  logic [9:0] i_h_count,
  input  logic [9:0] i_v_count,
  output logic       o_strobe
);

  logic [9:0] w_line;
  assign w_line = 10'(LINE);

  // Strobe for exactly the first pixel of the selected line
  always_comb begin
    o_strobe = (i_h_count == '0) && (i_v_count == w_line);
  end

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: runs N_TASKS game-logic tasks in order during vertical
// blanking, aborting whatever is still running at the deadline line.
// Optional feature macro: FRAME_SCHED_STATS_EN enables the saturating
// overrun counter; without it overrun_cnt is tied to zero.
module frame_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned N_TASKS       = 4,
  parameter int unsigned BLANK_LINE    = DEF_BLANK_LINE,
  parameter int unsigned DEADLINE_LINE = DEF_DEADLINE_LINE
) (
  input  logic               clk,
  input  logic               Reset_n,
  input  logic [9:0]         h_count,
  input  logic [9:0]         v_count,
  input  logic [N_TASKS-1:0] task_done,
  output logic [N_TASKS-1:0] task_start,
  output logic               task_abort,
  output logic               busy,
  output logic               frame_tick,
  output logic [7:0]         overrun_cnt
);

  localparam int unsigned      IDX_W    = (N_TASKS > 1) ? $clog2(N_TASKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TASKS - 1);

  logic w_blank;
  logic w_deadline;

  line_event #(.LINE(BLANK_LINE)) u_blank_evt (
    .i_h_count (h_count),
    .i_v_count (v_count),
    .o_strobe  (w_blank)
  );

  line_event #(.LINE(DEADLINE_LINE)) u_deadline_evt (
    .i_h_count (h_count),
    .i_v_count (v_count),
    .o_strobe  (w_deadline)
  );

  state_t             r_state,      w_state_nxt;
  logic [IDX_W-1:0]   r_idx,        w_idx_nxt;
  logic [N_TASKS-1:0] r_task_start, w_start_nxt;
  logic               r_abort,      w_abort_nxt;
  logic               r_busy,       w_busy_nxt;
  logic               r_tick,       w_tick_nxt;
  logic               w_done_cur;

  // A done strobe from the current task, masked while its own start pulse is
  // still on the output (the task cannot have finished yet).
  assign w_done_cur = task_done[r_idx] & ~r_task_start[r_idx];

  // Next-state and next-output decode; last-task completion beats the deadline,
  // the deadline beats advancing to a further task.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_start_nxt = '0;
    w_abort_nxt = 1'b0;
    w_tick_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_blank) begin
          w_state_nxt = WAIT;
          w_idx_nxt   = '0;
          w_start_nxt = N_TASKS'(1);
          w_busy_nxt  = 1'b1;
        end
      end
      WAIT: begin
        if (w_done_cur && (r_idx == LAST_IDX)) begin
          w_state_nxt = IDLE;
          w_tick_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (w_deadline) begin
          w_state_nxt = IDLE;
          w_abort_nxt = 1'b1;
          w_busy_nxt  = 1'b0;
        end else if (w_done_cur) begin
          w_idx_nxt   = r_idx + 1'b1;
          w_start_nxt = N_TASKS'(1) << (int'(r_idx) + 1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_task_start <= '0;
      r_abort      <= 1'b0;
      r_busy       <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_task_start <= w_start_nxt;
      r_abort      <= w_abort_nxt;
      r_busy       <= w_busy_nxt;
      r_tick       <= w_tick_nxt;
    end
  end

  assign task_start = r_task_start;
  assign task_abort = r_abort;
  assign busy       = r_busy;
  assign frame_tick = r_tick;

`ifdef FRAME_SCHED_STATS_EN
  logic [7:0] r_overrun;

  // Count every aborted frame, holding at 255
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_overrun <= '0;
    end else if (w_abort_nxt) begin
      r_overrun <= sat_inc8(r_overrun);
    end
  end

  assign overrun_cnt = r_overrun;
`else
  assign overrun_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler: directed scenarios plus randomized
// frames, every cycle compared against a behavioural scheduler model.
module tb_frame_scheduler;

  localparam int N  = 4;
  localparam int BL = 480;
  localparam int DL = 522;
`ifdef FRAME_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk;
  logic         Reset_n;
  logic [9:0]   h_count;
  logic [9:0]   v_count;
  logic [N-1:0] task_done;
  logic [N-1:0] task_start;
  logic         task_abort;
  logic         busy;
  logic         frame_tick;
  logic [7:0]   overrun_cnt;

  frame_scheduler #(
    .N_TASKS       (N),
    .BLANK_LINE    (BL),
    .DEADLINE_LINE (DL)
  ) dut (
    .clk         (clk),
    .Reset_n     (Reset_n),
    .h_count     (h_count),
    .v_count     (v_count),
    .task_done   (task_done),
    .task_start  (task_start),
    .task_abort  (task_abort),
    .busy        (busy),
    .frame_tick  (frame_tick),
    .overrun_cnt (overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int last_tick_cyc = -1;

  // Reference model: which task of the frame is outstanding
  bit       m_busy;
  bit       m_fresh;   // current task's start pulse is visible this cycle
  int       m_cur;
  int       m_ovr;
  logic [N-1:0] e_start;
  bit       e_abort;
  bit       e_tick;

  // Task responders: done raised lat cycles after start, held hold cycles
  int lat  [N];
  int hold [N];
  int due  [N];

  task automatic chk(input string tag, input int act, input int exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task model_reset();
    m_busy = 0; m_fresh = 0; m_cur = 0; m_ovr = 0;
  endtask

  task clear_resp();
    for (int k = 0; k < N; k++) due[k] = -1;
  endtask

  task set_lat(input int l, input int h);
    for (int k = 0; k < N; k++) begin lat[k] = l; hold[k] = h; end
  endtask

  task model_step(input bit blank, input bit dl, input logic [N-1:0] d);
    bit seen;
    e_start = '0; e_abort = 0; e_tick = 0;
    if (!m_busy) begin
      if (blank) begin
        m_busy = 1; m_cur = 0; e_start = N'(1);
      end
    end else begin
      seen = d[m_cur] && !m_fresh;
      if (seen && m_cur == N-1) begin
        e_tick = 1; m_busy = 0;
      end else if (dl) begin
        e_abort = 1; m_busy = 0;
        if (STATS && m_ovr < 255) m_ovr++;
      end else if (seen) begin
        m_cur++;
        e_start = N'(1) << m_cur;
      end
    end
    m_fresh = (e_start != '0);
  endtask

  // One clock: drive inputs, advance the model, compare all outputs after the edge
  task step(input bit blank, input bit dl, input logic [N-1:0] extra);
    logic [N-1:0] d;
    logic [14:0]  act;
    logic [14:0]  exp;
    int v;
    int h;
    d = extra;
    for (int k = 0; k < N; k++)
      if (due[k] >= 0 && cyc >= due[k] && cyc < due[k] + hold[k]) d[k] = 1'b1;
    if (blank) begin
      h = 0; v = BL;
    end else if (dl) begin
      h = 0; v = DL;
    end else begin
      v = $urandom_range(0, 524);
      h = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 799);
      if (h == 0 && (v == BL || v == DL)) v = v + 1;
    end
    h_count   = 10'(h);
    v_count   = 10'(v);
    task_done = d;
    model_step(blank, dl, d);
    for (int k = 0; k < N; k++)
      if (e_start[k]) due[k] = (lat[k] < 0) ? -1 : cyc + 1 + lat[k];
    @(posedge clk);
    #1;
    cyc++;
    exp = {e_start, e_abort, m_busy, e_tick, 8'(m_ovr)};
    act = {task_start, task_abort, busy, frame_tick, overrun_cnt};
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL cycle%0d outputs {start,abort,busy,tick,ovr} act=%h exp=%h", cyc, act, exp);
    end
    if (frame_tick === 1'b1) last_tick_cyc = cyc;
  endtask

  task idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, '0);
  endtask

  int b;
  int dl_at;
  logic [N-1:0] noise;

  initial begin
    Reset_n   = 1'b0;
    h_count   = 10'd1;
    v_count   = 10'd0;
    task_done = '0;
    model_reset();
    clear_resp();
    set_lat(3, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({task_start, task_abort, busy, frame_tick, overrun_cnt}), 0);
    Reset_n = 1'b1;
    idle(3);

    // Nominal frame, done 3 cycles after each start
    clear_resp(); set_lat(3, 1);
    b = cyc;
    step(1, 0, '0);
    idle(20);
    chk("nominal_tick_at_E17", last_tick_cyc, b + 17);

    // Task 2 hangs until the deadline line
    clear_resp(); set_lat(3, 1); lat[2] = -1;
    step(1, 0, '0);
    idle(15);
    step(0, 1, '0);
    idle(3);
    chk("hang_overrun", int'(overrun_cnt), STATS ? 1 : 0);
    chk("hang_busy_low", int'(busy), 0);

    // Next frame restarts from task 0
    clear_resp(); set_lat(3, 1);
    b = cyc;
    step(1, 0, '0);
    idle(20);
    chk("restart_tick_at_E17", last_tick_cyc, b + 17);

    // Stray done bits: task0 done during its start cycle, task3 done while task1 pending
    clear_resp(); set_lat(3, 1);
    b = cyc;
    step(1, 0, '0);
    step(0, 0, 4'b0001);
    idle(3);
    step(0, 0, 4'b1000);
    step(0, 0, 4'b1000);
    idle(14);
    chk("stray_done_tick_at_E17", last_tick_cyc, b + 17);

    // Last done coinciding with the deadline counts as completion
    clear_resp(); set_lat(3, 1);
    b = cyc;
    step(1, 0, '0);
    idle(15);
    step(0, 1, '0);
    chk("dl_vs_last_tick", last_tick_cyc, b + 17);
    chk("dl_vs_last_abort", int'(task_abort), 0);
    chk("dl_vs_last_ovr", int'(overrun_cnt), STATS ? 1 : 0);
    idle(3);

    // 256 forced aborts saturate the counter
    clear_resp(); set_lat(-1, 1);
    for (int i = 0; i < 256; i++) begin
      step(1, 0, '0);
      step(0, 0, '0);
      step(0, 1, '0);
    end
    idle(2);
    chk("overrun_saturated", int'(overrun_cnt), STATS ? 255 : 0);

    // Asynchronous reset while task 1 is pending
    clear_resp(); set_lat(3, 1);
    step(1, 0, '0);
    idle(6);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({task_start, task_abort, busy, frame_tick, overrun_cnt}), 0);
    model_reset();
    clear_resp();
    @(negedge clk);
    Reset_n = 1'b1;
    idle(5);
    b = cyc;
    step(1, 0, '0);
    chk("post_reset_start0", int'(task_start), 1);
    idle(20);
    chk("post_reset_tick_at_E17", last_tick_cyc, b + 17);

    // Randomized frames: random latencies, stray done bits, random deadline time
    for (int f = 0; f < 80; f++) begin
      clear_resp();
      for (int k = 0; k < N; k++) begin
        lat[k]  = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
        hold[k] = $urandom_range(1, 2);
      end
      step(1, 0, '0);
      dl_at = $urandom_range(8, 30);
      for (int i = 0; i < dl_at; i++) begin
        noise = ($urandom_range(0, 7) == 0) ? (N'(1) << $urandom_range(0, N-1)) : '0;
        step(($urandom_range(0, 15) == 0), 0, noise);
      end
      step(0, 1, '0);
      idle($urandom_range(1, 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
